// File: rtl/updown_counter.sv
// Up/down modulus counter, wrap or saturate at the bounds, registered tc pulse and sticky ovf; one-cycle latency.
// No backpressure: every en cycle is consumed. Define UPDOWN_COUNTER_PRESCALE_EN to step only every PRESCALE enabled cycles.
module updown_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter: WIDTH out of range 2..32");
  end
  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("updown_counter: PRESCALE out of range 2..256");
  end

  logic             step;
  logic [WIDTH-1:0] count_nxt;
  logic             bnd;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_cnt;

  // Prescaler only advances on cycles that would otherwise be steps.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      ps_cnt <= '0;
    end else if (en) begin
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PW'(1);
    end
  end

  assign step = en && !load && (ps_cnt == PS_LAST);
`else
  assign step = en && !load;
`endif

  always_comb begin
    count_nxt = count;
    bnd       = 1'b0;
    if (load) begin
      count_nxt = (load_val > modulus) ? modulus : load_val;
    end else if (step) begin
      if (dir) begin
        if (count < modulus) begin
          count_nxt = count + WIDTH'(1);
        end else begin
          bnd       = 1'b1;
          count_nxt = sat ? modulus : '0;
        end
      end else begin
        // Modulus lowered under a larger count: clamp quietly, no event.
        if (count > modulus) begin
          count_nxt = modulus;
        end else if (count == '0) begin
          bnd       = 1'b1;
          count_nxt = sat ? '0 : modulus;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= bnd;
      if (bnd) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
